// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   F stage plus the F/D pipeline register of the 5-stage MIPS core.
//   Holds the fetch PC, registers the fetched word into D and selects the
//   next PC from the D-stage control outputs.
//   Branches and jumps have an architectural delay slot. The word that sits
//   in F while a redirect is decided in D is not flushed.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset, overrides stall
//   stall      in   1   hazard unit freeze of PC and F/D register
//   f_instr    in  32   IM read data for f_pc (combinational IM)
//   d_branch   in   2   Branch control decoded from d_instr
//   d_jump     in   2   Jump control decoded from d_instr
//   d_cmp      in   1   D-stage comparator result, 1 = condition true
//   d_rs_data  in  32   forwarded GPR[rs] in D, jr target
//   f_pc       out 32   current fetch PC, IM address
//   d_instr    out 32   instruction word held in D
//   d_pc       out 32   PC of d_instr
//   d_pc8      out 32   d_pc + 8, jal link value
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] PC_RESET    = 32'h0000_3000,
   parameter logic [1:0]  BRANCH_COND = 2'b01,
   parameter logic [1:0]  JUMP_INDEX  = 2'b01,
   parameter logic [1:0]  JUMP_REG    = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] f_instr,
   input  logic [1:0]  d_branch,
   input  logic [1:0]  d_jump,
   input  logic        d_cmp,
   input  logic [31:0] d_rs_data,
   output logic [31:0] f_pc,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc8
);

   logic [31:0] f_pc_reg;
   logic [31:0] d_instr_reg;
   logic [31:0] d_pc_reg;

   logic [31:0] f_pc4;
   logic [31:0] d_pc4;
   logic [31:0] branch_offset;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] npc;

   assign f_pc4 = f_pc_reg + 32'd4;
   assign d_pc4 = d_pc_reg + 32'd4;

   // Word offset sign-extended to 32 bits and scaled to bytes.
   assign branch_offset = {{14{d_instr_reg[15]}}, d_instr_reg[15:0], 2'b00};
   assign branch_target = d_pc4 + branch_offset;

   // The region bits come from the delay-slot address, not from the jump itself.
   assign jump_target = {d_pc4[31:28], d_instr_reg[25:0], 2'b00};

   // Next-PC select. jr outranks j/jal, which outrank a taken branch.
   // Unused encodings (including 2'b11) fall through to sequential fetch.
   always_comb begin
      npc = f_pc4;
      if (d_jump == JUMP_REG) begin
         npc = d_rs_data;
      end else if (d_jump == JUMP_INDEX) begin
         npc = jump_target;
      end else if ((d_branch == BRANCH_COND) && d_cmp) begin
         npc = branch_target;
      end
   end

   // While stalled, the redirect is simply not applied. The controlling
   // instruction stays in D, so the select is evaluated again once stall drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_reg    <= PC_RESET;
         d_instr_reg <= 32'h0;
         d_pc_reg    <= 32'h0;
      end else if (!stall) begin
         f_pc_reg    <= npc;
         d_instr_reg <= f_instr;
         d_pc_reg    <= f_pc_reg;
      end
   end

   assign f_pc    = f_pc_reg;
   assign d_instr = d_instr_reg;
   assign d_pc    = d_pc_reg;
   assign d_pc8   = d_pc_reg + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Drives fetch_stage with a small instruction memory and a minimal decoder.
//   A behavioural model tracks the expected F and D state from MIPS semantics.
//   One negedge process compares every output against that model.
//   Hand-computed literals are also checked along the directed program.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] f_instr;
   logic [1:0]  d_branch;
   logic [1:0]  d_jump;
   logic        d_cmp;
   logic [31:0] d_rs_data;
   logic [31:0] f_pc;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [31:0] d_pc8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .f_instr   (f_instr),
      .d_branch  (d_branch),
      .d_jump    (d_jump),
      .d_cmp     (d_cmp),
      .d_rs_data (d_rs_data),
      .f_pc      (f_pc),
      .d_instr   (d_instr),
      .d_pc      (d_pc),
      .d_pc8     (d_pc8)
   );

   // Program image. Any address not listed reads as a nop.
   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0000_3008: return 32'h1000_FFFE; // beq  -2 words
         32'h0000_300C: return 32'h2401_000C; // delay slot marker
         32'h0000_3010: return 32'h0C00_0C40; // jal  0x3100
         32'h0000_3014: return 32'h2402_0014; // delay slot marker
         32'h0000_3100: return 32'h03E0_0008; // jr $31
         32'h0000_3104: return 32'h2403_3104; // delay slot marker
         32'h0000_3020: return 32'h1000_0010; // beq  +16 words -> 0x3064
         32'h0000_3064: return 32'h03E0_0008; // jr $31
         32'h0000_0000: return 32'h03E0_0008; // jr $31
         32'h0000_3006: return 32'h03E0_0008; // jr $31 (misaligned fetch)
         default:       return 32'h0;
      endcase
   endfunction

   assign f_instr = imem(f_pc);

   // Minimal control decoder for the opcodes the program uses.
   always_comb begin
      d_branch = 2'b00;
      d_jump   = 2'b00;
      if (d_instr[31:26] == 6'h04) d_branch = 2'b01;
      if (d_instr[31:26] == 6'h02 || d_instr[31:26] == 6'h03) d_jump = 2'b01;
      if (d_instr[31:26] == 6'h00 && d_instr[5:0] == 6'h08) d_jump = 2'b10;
   end

   // Behavioural model of the architectural F/D state.
   logic [31:0] m_fpc, m_dinstr, m_dpc;
   bit          m_valid = 1'b0;

   function automatic logic [31:0] model_npc();
      logic [5:0]  op;
      logic [31:0] link_base;
      logic signed [31:0] off;
      op        = m_dinstr[31:26];
      link_base = m_dpc + 32'd4;
      off       = 32'(signed'(m_dinstr[15:0])) * 4;
      if (op == 6'h00 && m_dinstr[5:0] == 6'h08) return d_rs_data;
      if (op == 6'h02 || op == 6'h03)
         return (link_base & 32'hF000_0000) | (32'(m_dinstr[25:0]) * 4);
      if (op == 6'h04 && d_cmp) return link_base + 32'(off);
      return m_fpc + 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge: drive inputs, advance the model, compare next negedge.
   task automatic step(input logic rst, input logic stl);
      logic [31:0] nf, ni, np;
      reset = rst;
      stall = stl;
      if (rst) begin
         nf = 32'h0000_3000; ni = 32'h0; np = 32'h0;
      end else if (stl) begin
         nf = m_fpc; ni = m_dinstr; np = m_dpc;
      end else begin
         nf = model_npc(); ni = imem(m_fpc); np = m_fpc;
      end
      @(posedge clk);
      m_fpc = nf; m_dinstr = ni; m_dpc = np; m_valid = 1'b1;
      @(negedge clk);
   endtask

   // Compare process: all outputs against the model on every cycle.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_f_pc",    f_pc,    m_fpc);
         chk("model_d_instr", d_instr, m_dinstr);
         chk("model_d_pc",    d_pc,    m_dpc);
         chk("model_d_pc8",   d_pc8,   m_dpc + 32'd8);
         $display("cycle t=%0t rst=%0b stall=%0b f_pc=%08h d_pc=%08h d_instr=%08h",
                  $time, reset, stall, f_pc, d_pc, d_instr);
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; d_cmp = 1'b0; d_rs_data = 32'h0;
      @(negedge clk);
      step(1, 0);
      step(1, 0);
      chk("rst_f_pc",    f_pc,    32'h0000_3000);
      chk("rst_d_instr", d_instr, 32'h0);
      chk("rst_d_pc8",   d_pc8,   32'h0000_0008);

      step(0, 0);
      chk("seq1_f_pc", f_pc, 32'h0000_3004);
      chk("seq1_d_pc", d_pc, 32'h0000_3000);
      step(0, 0);
      chk("seq2_f_pc", f_pc, 32'h0000_3008);
      step(0, 0);
      chk("seq3_f_pc", f_pc, 32'h0000_300C);

      // Taken backward beq at 0x3008.
      d_cmp = 1'b1;
      step(0, 0);
      chk("beq_taken_f_pc", f_pc,    32'h0000_3004);
      chk("beq_slot_instr", d_instr, 32'h2401_000C);
      chk("beq_slot_pc",    d_pc,    32'h0000_300C);
      step(0, 0);
      step(0, 0);

      // Same beq again, not taken.
      d_cmp = 1'b0;
      step(0, 0);
      chk("beq_nt_f_pc", f_pc, 32'h0000_3010);

      // jal then jr.
      step(0, 0);
      chk("jal_d_pc8", d_pc8, 32'h0000_3018);
      step(0, 0);
      chk("jal_f_pc", f_pc, 32'h0000_3100);
      step(0, 0);
      d_rs_data = 32'h0000_3018;
      step(0, 0);
      chk("jr_f_pc", f_pc, 32'h0000_3018);

      // Reach the beq at 0x3020, then stall with the branch taken.
      step(0, 0);
      step(0, 0);
      step(0, 0);
      d_cmp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 1);
         chk("stall_f_pc",    f_pc,    32'h0000_3024);
         chk("stall_d_pc",    d_pc,    32'h0000_3020);
         chk("stall_d_instr", d_instr, 32'h1000_0010);
      end
      step(0, 0);
      chk("stall_release_f_pc", f_pc, 32'h0000_3064);
      d_cmp = 1'b0;

      // jr to the last word of the address space, then wrap to 0.
      step(0, 0);
      d_rs_data = 32'hFFFF_FFFC;
      step(0, 0);
      chk("jr_top_f_pc", f_pc, 32'hFFFF_FFFC);
      step(0, 0);
      chk("wrap_f_pc", f_pc, 32'h0000_0000);

      // jr at 0 to a misaligned target, passed through unchanged.
      step(0, 0);
      d_rs_data = 32'h0000_3002;
      step(0, 0);
      chk("jr_misaligned_f_pc", f_pc, 32'h0000_3002);
      step(0, 0);
      chk("misaligned_seq_f_pc", f_pc, 32'h0000_3006);
      step(0, 0);
      chk("pending_jr_instr", d_instr, 32'h03E0_0008);

      // Reset together with stall and a pending jr.
      step(1, 1);
      chk("rst_stall_f_pc",    f_pc,    32'h0000_3000);
      chk("rst_stall_d_instr", d_instr, 32'h0);
      chk("rst_stall_d_pc8",   d_pc8,   32'h0000_0008);
      step(0, 0);
      chk("post_rst_f_pc", f_pc, 32'h0000_3004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage and F/D pipeline register of the 5-stage MIPS core.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word into D, where the control decoder consumes it.
- Computes the next PC from the D-stage decoder's Branch/Jump outputs and the D-stage comparator result, with architectural delay slots and hazard stalls.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- BRANCH_COND, 2'b01, Branch encoding for a conditional branch (beq class).
- JUMP_INDEX, 2'b01, Jump encoding for j/jal (26-bit index).
- JUMP_REG, 2'b10, Jump encoding for jr (register target).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit: freeze PC and F/D register.
- f_instr  in  32  instruction word returned combinationally by IM for f_pc.
- d_branch  in  2  Branch field decoded from d_instr.
- d_jump  in  2  Jump field decoded from d_instr.
- d_cmp  in  1  D-stage comparator result (1 = condition true).
- d_rs_data  in  32  forwarded GPR[rs] in D (jr target).
- f_pc  out  32  current fetch PC, to IM address.
- d_instr  out  32  registered instruction in D, to decoder.
- d_pc  out  32  PC of d_instr.
- d_pc8  out  32  d_pc + 8, link value for jal.

Behaviour:
- Reset (clk edge with reset=1, overrides stall):
  - f_pc = PC_RESET.
  - d_instr = 32'h0 (nop; decoder emits all-zero controls).
  - d_pc = 0, so d_pc8 = 8.
- d_pc8 is combinational: d_pc + 32'd8.
- Next-PC select (combinational, priority order):
  1. d_jump == JUMP_REG: npc = d_rs_data.
  2. d_jump == JUMP_INDEX: npc = {d_pc[31:28] + carry-free of (d_pc+4)[31:28], d_instr[25:0], 2'b00}. Use (d_pc+4)[31:28].
  3. d_branch == BRANCH_COND and d_cmp: npc = d_pc + 4 + (sign-extend(d_instr[15:0]) << 2).
  4. Otherwise: npc = f_pc + 4.
- Delay slot: the word in F during a D-stage redirect is the delay slot. It still advances into D normally; no flush and no bubble.
- Any other d_branch/d_jump encoding (incl. 2'b11) is treated as no redirect, selecting f_pc + 4.
- Normal cycle (reset=0, stall=0), at clk edge:
  - f_pc <= npc.
  - d_instr <= f_instr.
  - d_pc <= f_pc.
- Stall cycle (stall=1): f_pc, d_instr and d_pc hold. The redirect is not taken; it is re-evaluated when stall drops, because the D instruction is still present.
- Arithmetic is 32-bit modulo 2^32. Wrap at 32'hFFFF_FFFC + 4 gives 0. Backward branch offsets sign-extend correctly.
- No alignment check; jr to a misaligned target is passed through unchanged.
- Reset asserted mid-stall or mid-redirect wins: registers take reset values on that edge.
- Latency: instruction fetched at edge N appears on d_instr after edge N+1. A redirect decided in D takes effect on f_pc after the next unstalled edge.

Test Plan:
- Reset, then release: f_pc = 32'h3000, d_instr = 0, d_pc8 = 8. Next edge: d_pc = 32'h3000, f_pc = 32'h3004.
- Sequential fetch, 4 edges with no stall: f_pc goes 3004, 3008, 300C, 3010; d_pc lags by one step.
- beq at 32'h3008, imm = 16'hFFFE, d_cmp=1: f_pc becomes 32'h3004. Delay slot at 300C still appears on d_instr with d_pc = 300C. Same with d_cmp=0: f_pc = 32'h3010.
- jal at 32'h3010, index 26'h0000C40: f_pc becomes 32'h0000_3100, d_pc8 = 32'h3018. Follow with jr (d_rs_data = 32'h3018): f_pc = 32'h3018.
- Hold stall=1 for 3 cycles with beq taken in D: f_pc, d_instr and d_pc are unchanged throughout. On the first edge after stall=0, f_pc = branch target.
- Assert reset together with stall=1 and a pending jr: f_pc = 32'h3000 and d_instr = 0 on that edge.
